// File: rtl/popcount_arbiter_if.sv
// Request/result bundle for popcount_arbiter.
// res_words is present only when POPCOUNT_ARBITER_WORDCOUNT_EN is defined.
interface popcount_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned ACC_W = 16
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               res_valid;
    logic               res_ready;
    logic [ID_W-1:0]    res_id;
    logic [ACC_W-1:0]   res_count;
    logic               res_overflow;
`ifdef POPCOUNT_ARBITER_WORDCOUNT_EN
    logic [ACC_W-1:0]   res_words;
`endif

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready,
        input  res_valid,
        output res_ready,
        input  res_id,
        input  res_count,
`ifdef POPCOUNT_ARBITER_WORDCOUNT_EN
        input  res_words,
`endif
        input  res_overflow
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready,
        output res_valid,
        input  res_ready,
        output res_id,
        output res_count,
`ifdef POPCOUNT_ARBITER_WORDCOUNT_EN
        output res_words,
`endif
        output res_overflow
    );
endinterface

// File: rtl/popcount_arbiter.sv
// Round-robin shared 32-bit popcount with saturating per-frame accumulation.
// Optional per-frame word counter (res_words) enabled by POPCOUNT_ARBITER_WORDCOUNT_EN.
module popcount_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned ACC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    popcount_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StStream, StDrain, StResult} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [ID_W-1:0]    r_grant;
    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    w_pick;
    logic               w_any;
    int                 w_best;
    int                 w_dist;
    logic [ACC_W-1:0]   r_acc;
    logic [5:0]         r_pc;
    logic               r_pc_vld;
    logic               r_ovf;
    logic               w_start;
    logic               w_accept;
    logic               w_last;
    logic [31:0]        w_word;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_sat;
    logic [NREQ-1:0]    w_ready;
    logic               w_res_valid;

    function automatic logic [5:0] bit_counter(input logic [31:0] word);
        logic [5:0] cnt;
        cnt = '0;
        for (int k = 0; k < 32; k++) begin
            cnt = cnt + {5'd0, word[k]};
        end
        return cnt;
    endfunction

    // Pick the valid requester at the smallest rotational distance past last_grant.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_best = int'(NREQ);
        w_dist = 0;
        for (int j = 0; j < int'(NREQ); j++) begin
            w_dist = (j + int'(NREQ) - 1 - int'(r_last_grant)) % int'(NREQ);
            if (bus.req_valid[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = ID_W'(j);
                w_any  = 1'b1;
            end
        end
    end

    assign w_word    = bus.req_data[{r_grant, 5'd0} +: 32];
    assign w_last    = bus.req_last[r_grant];
    assign w_accept  = w_ready[r_grant] & bus.req_valid[r_grant];
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 5){1'b0}}, r_pc};
    assign w_acc_sat = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_any) w_state_next = StStream;
            StStream: if (w_accept && w_last) w_state_next = StDrain;
            StDrain:  w_state_next = StResult;
            StResult: if (bus.res_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_ready     = '0;
        w_res_valid = 1'b0;
        w_start     = 1'b0;
        unique case (r_state)
            StIdle:   w_start = w_any;
            StStream: w_ready[r_grant] = 1'b1;
            StResult: w_res_valid = 1'b1;
            default:  ;
        endcase
    end

`ifdef POPCOUNT_ARBITER_WORDCOUNT_EN
    logic [ACC_W-1:0] r_words;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_words <= '0;
        end else if (w_start) begin
            r_words <= '0;
        end else if (w_accept && (r_words != '1)) begin
            r_words <= r_words + ACC_W'(1);
        end
    end

    assign bus.res_words = w_res_valid ? r_words : '0;
`endif

    // pc_reg is folded one cycle after its accept; the final fold happens in StDrain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= ID_W'(NREQ - 1);
            r_acc        <= '0;
            r_pc         <= '0;
            r_pc_vld     <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (r_pc_vld) begin
                r_acc <= w_acc_sat;
                r_ovf <= r_ovf | w_sum[ACC_W];
            end
            r_pc_vld <= w_accept;
            if (w_accept) begin
                r_pc <= bit_counter(w_word);
            end
            if (w_start) begin
                r_grant  <= w_pick;
                r_acc    <= '0;
                r_pc     <= '0;
                r_pc_vld <= 1'b0;
                r_ovf    <= 1'b0;
            end
            if (w_res_valid && bus.res_ready) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign bus.req_ready    = w_ready;
    assign bus.res_valid    = w_res_valid;
    assign bus.res_id       = w_res_valid ? r_grant : '0;
    assign bus.res_count    = w_res_valid ? r_acc : '0;
    assign bus.res_overflow = w_res_valid & r_ovf;
endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter (NREQ=4, ACC_W=8 so saturation is reachable).
module tb_popcount_arbiter;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] words [16];

    popcount_arbiter_if #(.NREQ(4), .ID_W(2), .ACC_W(8)) bus ();

    popcount_arbiter #(.NREQ(4), .ID_W(2), .ACC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int r);
        int t;
        t = 0;
        while (!bus.req_ready[r] && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) check_eq("grant_wait", 32'(bus.req_ready[r]), 1);
    endtask

    // Streams words[0..n-1] from requester r; drops valid 3 cycles after word stall_at.
    task automatic send_frame(input int r, input int n, input int stall_at);
        for (int i = 0; i < n; i++) begin
            bus.req_valid[r]          = 1'b1;
            bus.req_data[r*32 +: 32]  = words[i];
            bus.req_last[r]           = (i == n - 1);
            wait_ready(r);
            step();
            if (i == stall_at) begin
                bus.req_valid[r] = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check_eq("stall_grant", 32'(bus.req_ready), 32'd1 << r);
                    step();
                end
            end
        end
        bus.req_valid[r] = 1'b0;
        bus.req_last[r]  = 1'b0;
    endtask

    // Called one cycle after the last accept; consumes the result (res_ready=1).
    task automatic expect_result(input string tag, input logic [31:0] id, input logic [31:0] cnt,
                                 input logic [31:0] ovf, input logic [31:0] nw);
        check_eq({tag, "_lat1"}, 32'(bus.res_valid), 0);
        step();
        check_eq({tag, "_valid"}, 32'(bus.res_valid), 1);
        check_eq({tag, "_id"}, 32'(bus.res_id), id);
        check_eq({tag, "_count"}, 32'(bus.res_count), cnt);
        check_eq({tag, "_ovf"}, 32'(bus.res_overflow), ovf);
`ifdef POPCOUNT_ARBITER_WORDCOUNT_EN
        check_eq({tag, "_words"}, 32'(bus.res_words), nw);
`endif
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.req_ready), 0);
        check_eq({tag, "_valid"}, 32'(bus.res_valid), 0);
        check_eq({tag, "_id"}, 32'(bus.res_id), 0);
        check_eq({tag, "_count"}, 32'(bus.res_count), 0);
        check_eq({tag, "_ovf"}, 32'(bus.res_overflow), 0);
`ifdef POPCOUNT_ARBITER_WORDCOUNT_EN
        check_eq({tag, "_words"}, 32'(bus.res_words), 0);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int k;
        int exp_id;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b1;
        step();
        step();
        check_idle_outputs("reset");
        reset = 1'b0;

        // Single frame: 32 + 4 = 36
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h0000_000F;
        send_frame(0, 2, -1);
        expect_result("single", 0, 36, 0, 2);

        // Round-robin from reset with all requesters presenting 1-word frames
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_last  = 4'hF;
        bus.req_data  = {4{32'h0000_0001}};
        k = 0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            exp_id = k % 4;
            check_eq("rr_onehot", 32'(bus.req_ready) & ~(32'd1 << exp_id), 0);
            if (bus.res_valid) begin
                check_eq("rr_id", 32'(bus.res_id), 32'(exp_id));
                check_eq("rr_count", 32'(bus.res_count), 1);
                k++;
            end
            step();
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        check_eq("rr_results", 32'(k), 6);

        // Backpressure: requester 3 (last grant 1), requester 0 waits behind it
        bus.res_ready = 1'b0;
        words[0] = 32'h0000_00FF;
        send_frame(3, 1, -1);
        check_eq("bp_lat1", 32'(bus.res_valid), 0);
        step();
        bus.req_valid[0]    = 1'b1;
        bus.req_data[31:0]  = 32'h0F0F_0F0F;
        bus.req_last[0]     = 1'b1;
        for (int s = 0; s < 5; s++) begin
            check_eq("bp_valid", 32'(bus.res_valid), 1);
            check_eq("bp_id", 32'(bus.res_id), 3);
            check_eq("bp_count", 32'(bus.res_count), 8);
            check_eq("bp_ready", 32'(bus.req_ready), 0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        check_eq("bp_idle_ready", 32'(bus.req_ready), 0);
        check_eq("bp_idle_valid", 32'(bus.res_valid), 0);
        step();
        check_eq("bp_next_grant", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid[0] = 1'b0;
        bus.req_last[0]  = 1'b0;
        expect_result("bp_next", 0, 16, 0, 1);

        // Saturation: 9 x 32 = 288 > 255
        for (int i = 0; i < 9; i++) words[i] = 32'hFFFF_FFFF;
        send_frame(1, 9, -1);
        expect_result("sat", 1, 255, 1, 9);
        words[0] = 32'h0000_0003;
        send_frame(1, 1, -1);
        expect_result("sat_next", 1, 2, 0, 1);

        // Stall: requester 2 pauses; requester 0 waits with its word held
        bus.req_valid[0]   = 1'b1;
        bus.req_data[31:0] = 32'h0000_0007;
        bus.req_last[0]    = 1'b1;
        words[0] = 32'hF000_0000;
        words[1] = 32'h00FF_0000;
        words[2] = 32'h0000_0001;
        send_frame(2, 3, 0);
        expect_result("stall", 2, 13, 0, 3);
        words[0] = 32'h0000_0007;
        send_frame(0, 1, -1);
        expect_result("held", 0, 3, 0, 1);

        // Word count frame, then a zero-popcount frame
        for (int i = 0; i < 7; i++) words[i] = 32'h8000_0001;
        send_frame(1, 7, -1);
        expect_result("wc7", 1, 14, 0, 7);
        words[0] = 32'h0000_0000;
        send_frame(1, 1, -1);
        expect_result("wc1", 1, 0, 0, 1);

        // Reset mid-frame: requester 3 granted (last grant 1), then reset
        bus.req_valid[3]     = 1'b1;
        bus.req_data[127:96] = 32'h0000_FFFF;
        bus.req_last[3]      = 1'b0;
        wait_ready(3);
        check_eq("mid_grant", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid[0]   = 1'b1;
        bus.req_data[31:0] = 32'h0000_0001;
        bus.req_last[0]    = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("mid_reset");
        step();
        check_eq("post_reset_grant", 32'(bus.req_ready), 32'h1);
        bus.req_valid[3] = 1'b0;
        words[0] = 32'h0000_0001;
        send_frame(0, 1, -1);
        expect_result("post_reset", 0, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
